// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential/redirected fetches and buffers
// returned instructions with their PCs in a 2-entry in-order FIFO toward OF.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  output logic [63:0] If_Payld_o,
  output logic        If_Valid_o,
  input  logic        Of_Ready_i
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_of_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  if_of_t      fifo_mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic [2:0]  occupancy;
  logic        pop, push, flush, issue;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Start)  state_next = RUN;
      RUN:  if (!Start) state_next = IDLE;
    endcase

    // Outputs are forced to their reset values while Rst is low.
    If_Valid_o = Rst && (count != 2'd0);
    pop        = If_Valid_o && Of_Ready_i;
    occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    flush      = (state == RUN) && Br_Taken;
    issue      = Rst && (state == RUN) && Start && !Br_Taken && (occupancy < 3'd2);
    push       = inflight && !flush;
    Imem_Req   = issue;
    Imem_Addr  = Rst ? pc : RESET_PC;
    If_Payld_o = If_Valid_o ? fifo_mem[rd_ptr] : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'(PC_STEP);
      end else if (Br_Taken) begin
        pc <= Br_Target & 32'hFFFF_FFFC;
      end
      // A redirect drops the buffer and the response arriving this cycle.
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (push) begin
          fifo_mem[wr_ptr] <= {inflight_pc, Imem_Data};
          wr_ptr           <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  no_overflow: assert property (@(posedge Clk) disable iff (!Rst)
    !(push && !pop && (count == 2'd2)));

endmodule
